// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard controller bundle: ID-slot description in, pipeline
// control and status out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_regS;
  logic [2:0]       id_regT;
  logic             id_uses_s;
  logic             id_uses_t;
  logic             id_wr_en;
  logic [2:0]       id_wr_dst;
  logic             id_halt;
  logic             ex_redirect;
  logic             stall_if;
  logic             bubble_id;
  logic             flush_ifid;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_regS, id_regT, id_uses_s, id_uses_t,
           id_wr_en, id_wr_dst, id_halt, ex_redirect,
    input  stall_if, bubble_id, flush_ifid, halted, stall_cycles
  );

  modport slave (
    input  id_valid, id_regS, id_regT, id_uses_s, id_uses_t,
           id_wr_en, id_wr_dst, id_halt, ex_redirect,
    output stall_if, bubble_id, flush_ifid, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage RAW hazard detection, redirect kill and HALT drain sequencing
// for the 5-stage pipeline.
module hazard_ctrl #(
  parameter bit BYPASS_WB = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             ex_v_r;
  logic             mem_v_r;
  logic             wb_v_r;
  logic [2:0]       ex_dst_r;
  logic [2:0]       mem_dst_r;
  logic [2:0]       wb_dst_r;
  logic             halted_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             haz_s;
  logic             issue_s;
  logic             stall_if_s;
  logic             bubble_id_s;
  logic             flush_ifid_s;
  logic             table_empty_s;

  function automatic logic in_flight_f(
    input logic [2:0] r,
    input logic       ev, input logic [2:0] ed,
    input logic       mv, input logic [2:0] md,
    input logic       wv, input logic [2:0] wd,
    input logic       chk_wb
  );
    in_flight_f = (ev && (ed == r)) || (mv && (md == r)) ||
                  (chk_wb && wv && (wd == r));
  endfunction

  // RAW check of both decode read ports against the in-flight writers
  always_comb begin
    haz_s = (bus.id_uses_s && in_flight_f(bus.id_regS, ex_v_r, ex_dst_r, mem_v_r, mem_dst_r,
                                          wb_v_r, wb_dst_r, !BYPASS_WB)) ||
            (bus.id_uses_t && in_flight_f(bus.id_regT, ex_v_r, ex_dst_r, mem_v_r, mem_dst_r,
                                          wb_v_r, wb_dst_r, !BYPASS_WB));
    table_empty_s = !ex_v_r && !mem_v_r && !wb_v_r;
  end

  // Next state and pipeline control; redirect wins over a hazard in RUN
  always_comb begin
    state_nxt_s  = state_r;
    issue_s      = 1'b0;
    stall_if_s   = 1'b1;
    bubble_id_s  = 1'b1;
    flush_ifid_s = 1'b0;
    case (state_r)
      RUN: begin
        issue_s      = bus.id_valid && !haz_s && !bus.ex_redirect;
        stall_if_s   = haz_s && bus.id_valid && !bus.ex_redirect;
        bubble_id_s  = !issue_s;
        flush_ifid_s = bus.ex_redirect;
        if (issue_s && bus.id_halt) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: begin
        if (table_empty_s) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HALTED: begin
        state_nxt_s = HALTED;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State register and sticky halted flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      halted_r <= (state_nxt_s == HALTED);
    end
  end

  // In-flight writer table; HALT issues without claiming a destination
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_v_r    <= 1'b0;
      mem_v_r   <= 1'b0;
      wb_v_r    <= 1'b0;
      ex_dst_r  <= 3'd0;
      mem_dst_r <= 3'd0;
      wb_dst_r  <= 3'd0;
    end else begin
      wb_v_r    <= mem_v_r;
      wb_dst_r  <= mem_dst_r;
      mem_v_r   <= ex_v_r;
      mem_dst_r <= ex_dst_r;
      ex_v_r    <= issue_s && bus.id_wr_en && !bus.id_halt;
      ex_dst_r  <= bus.id_wr_dst;
    end
  end

  // Saturating count of hazard stalls; drain stalls are not hazards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == RUN) && stall_if_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_if     = stall_if_s;
  assign bus.bubble_id    = bubble_id_s;
  assign bus.flush_ifid   = flush_ifid_s;
  assign bus.halted       = halted_r;
  assign bus.stall_cycles = stall_cnt_r;

endmodule
